inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
Opcode fetch stage directly upstream of the microcode control unit. Reads instruction bytes from the memory bus at the program counter and folds the 0xCB prefix into a 9-bit opcode index. Presents the opcode byte and CB flag that address the 512-entry metadata table. Also fetches 8/16-bit immediates on request and owns the PC.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
CB_PREFIX, 8'hCB, prefix byte selecting the upper 256 metadata entries

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
fetch_start  input  1  pulse: current instruction retired, fetch next opcode at pc
imm_fetch  input  1  pulse: fetch one immediate byte at pc
pc_load  input  1  load pc from pc_load_value (jump/call/ret)
pc_load_value  input  16  new PC
mem_req  output  1  bus request, held until ack
mem_addr  output  16  bus address, stable while mem_req=1
mem_rdata  input  8  read data, valid when mem_ack=1
mem_ack  input  1  one-cycle read completion
inst_buffer  output  8  opcode byte (second byte if CB-prefixed)
inst_is_cb  output  1  opcode was CB-prefixed; opcode index = {inst_is_cb, inst_buffer}
inst_valid  output  1  inst_buffer/inst_is_cb valid
imm_data  output  16  immediate shift register; new byte enters [15:8], old [15:8] moves to [7:0]
imm_valid  output  1  pulse, one cycle after immediate byte captured
pc  output  16  current program counter
busy  output  1  FSM not in IDLE/READY

Behaviour:
- Reset values: pc=RESET_PC, mem_req=0, mem_addr=0, inst_buffer=0, inst_is_cb=0, inst_valid=0, imm_data=0, imm_valid=0, busy=0; state=BOOT. Reset mid-transaction drops mem_req asynchronously; the late ack is ignored (state not OP_REQ/CB_REQ/IMM_REQ).
- States: BOOT, OP_REQ, CB_REQ, IMM_REQ, READY.
- BOOT: first clock after reset deasserts -> OP_REQ.
- Bus: entering a *_REQ state registers mem_req=1, mem_addr=pc. Data captured on the cycle mem_ack=1; mem_req=0 next cycle; pc increments by 1 on every accepted byte, 0xFFFF wraps to 0x0000.
- OP_REQ on ack: byte==CB_PREFIX -> CB_REQ, inst_is_cb<=1. Otherwise inst_buffer<=byte, inst_is_cb<=0, inst_valid<=1, -> READY.
- CB_REQ on ack: inst_buffer<=byte, inst_valid<=1, -> READY. A second 0xCB is a normal opcode byte (index 0x1CB).
- Latency: fetch_start at cycle N -> mem_req=1 at N+1; ack at M -> inst_valid=1 at M+1 (non-CB).
- READY: fetch_start -> inst_valid<=0, OP_REQ. imm_fetch -> IMM_REQ, inst_valid stays 1. IMM_REQ on ack: shift imm_data, imm_valid=1 one cycle, -> READY.
- Simultaneous inputs in READY: pc_load > fetch_start > imm_fetch. pc_load with fetch_start in same cycle: PC loaded, then fetch at new PC.
- pc_load in READY/BOOT: pc<=pc_load_value next cycle. pc_load during *_REQ: the bus transaction completes (no abort), its data is discarded, pc<=pc_load_value, no increment, then OP_REQ restarts at the new PC with inst_valid=0.
- fetch_start/imm_fetch while busy=1 are ignored.

Optional Feature:
INST_PREFETCH_EN:
- Defined: adds a 1-byte prefetch buffer with valid bit. In READY with buffer empty and no pending request, issues a read at pc. The byte is stored and pc incremented. fetch_start with buffer valid consumes it with no bus cycle (non-CB: inst_valid 1 cycle after fetch_start; CB byte: -> CB_REQ). imm_fetch likewise consumes it. pc_load invalidates the buffer; in-flight data is discarded.
- Undefined: no speculative reads; mem_req only in response to fetch_start/imm_fetch/boot.

Test Plan:
- Reset, mem returns 0x3E at 0x0000 with 2-cycle ack delay -> mem_addr=0x0000, inst_buffer=0x3E, inst_is_cb=0, inst_valid=1, pc=0x0001.
- Bytes 0xCB,0x7C at 0x0100 -> two bus reads; inst_buffer=0x7C, inst_is_cb=1, pc=0x0102.
- imm_fetch twice, bytes 0x34,0x12 -> imm_data=0x1234, two imm_valid pulses, inst_valid held.
- pc_load=0x8000 during OP_REQ, before ack -> ack data dropped, next mem_addr=0x8000, pc=0x8001 after fetch.
- pc=0xFFFF fetch -> pc wraps to 0x0000; reset asserted with mem_req=1 -> mem_req=0 same cycle, pc=RESET_PC.
- INST_PREFETCH_EN: after READY, fetch_start -> inst_valid next cycle with mem_req low; pc_load -> prefetch invalidated, new read at load value.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// Memory read bus between the fetch unit (master) and instruction memory (slave).
// One outstanding read: mem_req held with a stable mem_addr until a one-cycle mem_ack.
interface inst_fetch_unit_if;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        mem_ack;

   modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
   modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/inst_fetch_unit.sv
// Opcode/immediate fetch stage owning the PC; folds the CB prefix into a 9-bit opcode index.
// Latency: request 1 cycle after fetch_start, opcode valid 1 cycle after ack. INST_PREFETCH_EN adds a 1-byte prefetch buffer.
module inst_fetch_unit #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [7:0]  CB_PREFIX = 8'hCB
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      fetch_start,
   input  logic                      imm_fetch,
   input  logic                      pc_load,
   input  logic [15:0]               pc_load_value,
   inst_fetch_unit_if.master         bus,
   output logic [7:0]                inst_buffer,
   output logic                      inst_is_cb,
   output logic                      inst_valid,
   output logic [15:0]               imm_data,
   output logic                      imm_valid,
   output logic [15:0]               pc,
   output logic                      busy
);

   typedef enum logic [2:0] {BOOT, OP_REQ, CB_REQ, IMM_REQ, READY} state_t;

   state_t      state, state_nxt;
   logic [15:0] pc_nxt, pc_inc;
   logic        req_q, req_nxt;
   logic [15:0] addr_q, addr_nxt;
   logic [7:0]  buf_nxt;
   logic        cb_nxt, valid_nxt, imm_vld_nxt;
   logic [15:0] imm_nxt;
   // Set when a pc_load lands mid-transaction: the outstanding read is drained and thrown away.
   logic        drop_q, drop_nxt;

`ifdef INST_PREFETCH_EN
   logic        pf_vld, pf_vld_nxt;
   logic        pf_pend, pf_pend_nxt;
   logic [7:0]  pf_dat, pf_dat_nxt;
   logic        pf_take, pf_live, pf_have;
   logic [7:0]  pf_byte;
   logic [15:0] pc_after;
`endif

   assign bus.mem_req  = req_q;
   assign bus.mem_addr = addr_q;
   assign pc_inc       = pc + 16'd1;
   assign busy         = (state == OP_REQ) || (state == CB_REQ) || (state == IMM_REQ);

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      req_nxt     = req_q;
      addr_nxt    = addr_q;
      buf_nxt     = inst_buffer;
      cb_nxt      = inst_is_cb;
      valid_nxt   = inst_valid;
      imm_nxt     = imm_data;
      imm_vld_nxt = 1'b0;
      drop_nxt    = drop_q;
`ifdef INST_PREFETCH_EN
      pf_vld_nxt  = pf_vld;
      pf_pend_nxt = pf_pend;
      pf_dat_nxt  = pf_dat;
      pf_take     = pf_pend && bus.mem_ack && !drop_q;
      pf_live     = pf_pend && !bus.mem_ack;
      pf_have     = pf_vld || pf_take;
      pf_byte     = pf_vld ? pf_dat : bus.mem_rdata;
      pc_after    = pf_take ? pc_inc : pc;
`endif
      case (state)
         BOOT: begin
            state_nxt = OP_REQ;
            req_nxt   = 1'b1;
            if (pc_load) begin
               pc_nxt   = pc_load_value;
               addr_nxt = pc_load_value;
            end else begin
               addr_nxt = pc;
            end
         end
         OP_REQ, CB_REQ, IMM_REQ: begin
            if (pc_load) begin
               pc_nxt    = pc_load_value;
               drop_nxt  = 1'b1;
               valid_nxt = 1'b0;
            end
            if (bus.mem_ack) begin
               req_nxt = 1'b0;
               if (drop_q || pc_load) begin
                  // Redirected: no pc increment, restart opcode fetch at the loaded PC.
                  drop_nxt  = 1'b0;
                  state_nxt = OP_REQ;
                  req_nxt   = 1'b1;
                  addr_nxt  = pc_load ? pc_load_value : pc;
                  valid_nxt = 1'b0;
                  cb_nxt    = 1'b0;
               end else begin
                  pc_nxt = pc_inc;
                  if (state == OP_REQ) begin
                     if (bus.mem_rdata == CB_PREFIX) begin
                        cb_nxt    = 1'b1;
                        state_nxt = CB_REQ;
                        req_nxt   = 1'b1;
                        addr_nxt  = pc_inc;
                     end else begin
                        buf_nxt   = bus.mem_rdata;
                        cb_nxt    = 1'b0;
                        valid_nxt = 1'b1;
                        state_nxt = READY;
                     end
                  end else if (state == CB_REQ) begin
                     buf_nxt   = bus.mem_rdata;
                     valid_nxt = 1'b1;
                     state_nxt = READY;
                  end else begin
                     imm_nxt     = {bus.mem_rdata, imm_data[15:8]};
                     imm_vld_nxt = 1'b1;
                     state_nxt   = READY;
                  end
               end
            end
         end
         READY: begin
`ifdef INST_PREFETCH_EN
            if (pf_pend && bus.mem_ack) begin
               pf_pend_nxt = 1'b0;
               req_nxt     = 1'b0;
               drop_nxt    = 1'b0;
            end
            if (pf_take) begin
               pc_nxt     = pc_inc;
               pf_vld_nxt = 1'b1;
               pf_dat_nxt = bus.mem_rdata;
            end
            if (pc_load) begin
               pc_nxt     = pc_load_value;
               pf_vld_nxt = 1'b0;
               if (pf_live) drop_nxt = 1'b1;
               if (fetch_start) begin
                  state_nxt = OP_REQ;
                  valid_nxt = 1'b0;
                  if (pf_live) begin
                     pf_pend_nxt = 1'b0;
                  end else begin
                     req_nxt  = 1'b1;
                     addr_nxt = pc_load_value;
                  end
               end
            end else if (fetch_start) begin
               if (pf_have) begin
                  pf_vld_nxt = 1'b0;
                  if (pf_byte == CB_PREFIX) begin
                     cb_nxt    = 1'b1;
                     valid_nxt = 1'b0;
                     state_nxt = CB_REQ;
                     req_nxt   = 1'b1;
                     addr_nxt  = pc_after;
                  end else begin
                     buf_nxt   = pf_byte;
                     cb_nxt    = 1'b0;
                     valid_nxt = 1'b1;
                  end
               end else begin
                  // An in-flight prefetch at pc simply becomes the opcode read.
                  state_nxt   = OP_REQ;
                  valid_nxt   = 1'b0;
                  pf_pend_nxt = 1'b0;
                  if (!pf_live) begin
                     req_nxt  = 1'b1;
                     addr_nxt = pc;
                  end
               end
            end else if (imm_fetch) begin
               if (pf_have) begin
                  pf_vld_nxt  = 1'b0;
                  imm_nxt     = {pf_byte, imm_data[15:8]};
                  imm_vld_nxt = 1'b1;
               end else begin
                  state_nxt   = IMM_REQ;
                  pf_pend_nxt = 1'b0;
                  if (!pf_live) begin
                     req_nxt  = 1'b1;
                     addr_nxt = pc;
                  end
               end
            end else if (!pf_vld && !pf_pend) begin
               req_nxt     = 1'b1;
               addr_nxt    = pc;
               pf_pend_nxt = 1'b1;
            end
`else
            if (pc_load) begin
               pc_nxt = pc_load_value;
               if (fetch_start) begin
                  state_nxt = OP_REQ;
                  req_nxt   = 1'b1;
                  addr_nxt  = pc_load_value;
                  valid_nxt = 1'b0;
               end
            end else if (fetch_start) begin
               state_nxt = OP_REQ;
               req_nxt   = 1'b1;
               addr_nxt  = pc;
               valid_nxt = 1'b0;
            end else if (imm_fetch) begin
               state_nxt = IMM_REQ;
               req_nxt   = 1'b1;
               addr_nxt  = pc;
            end
`endif
         end
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         req_q       <= 1'b0;
         addr_q      <= 16'h0000;
         inst_buffer <= 8'h00;
         inst_is_cb  <= 1'b0;
         inst_valid  <= 1'b0;
         imm_data    <= 16'h0000;
         imm_valid   <= 1'b0;
         drop_q      <= 1'b0;
`ifdef INST_PREFETCH_EN
         pf_vld      <= 1'b0;
         pf_pend     <= 1'b0;
         pf_dat      <= 8'h00;
`endif
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         req_q       <= req_nxt;
         addr_q      <= addr_nxt;
         inst_buffer <= buf_nxt;
         inst_is_cb  <= cb_nxt;
         inst_valid  <= valid_nxt;
         imm_data    <= imm_nxt;
         imm_valid   <= imm_vld_nxt;
         drop_q      <= drop_nxt;
`ifdef INST_PREFETCH_EN
         pf_vld      <= pf_vld_nxt;
         pf_pend     <= pf_pend_nxt;
         pf_dat      <= pf_dat_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: byte-array memory with programmable ack delay,
// directed scenarios plus randomized fetch/immediate traffic against a byte-level program model.
module tb_inst_fetch_unit;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_start = 1'b0;
   logic        imm_fetch = 1'b0;
   logic        pc_load = 1'b0;
   logic [15:0] pc_load_value = 16'h0000;
   logic [7:0]  inst_buffer;
   logic        inst_is_cb, inst_valid, imm_valid, busy;
   logic [15:0] imm_data, pc;

   int total = 0;
   int bad = 0;
   int imm_pulses = 0;
   int ack_delay = 0;
   int wcnt = 0;
   logic [7:0]  mem [0:65535];
   logic [15:0] addr_log [$];

   inst_fetch_unit_if bus ();

   inst_fetch_unit #(.RESET_PC(16'h0000), .CB_PREFIX(8'hCB)) dut (
      .clock(clock), .reset(reset), .fetch_start(fetch_start), .imm_fetch(imm_fetch),
      .pc_load(pc_load), .pc_load_value(pc_load_value), .bus(bus),
      .inst_buffer(inst_buffer), .inst_is_cb(inst_is_cb), .inst_valid(inst_valid),
      .imm_data(imm_data), .imm_valid(imm_valid), .pc(pc), .busy(busy)
   );

   always #5 clock = ~clock;

   // Memory responder: ack_delay idle cycles after mem_req is seen, then a one-cycle ack.
   initial begin
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 8'h00;
      forever begin
         @(negedge clock);
         if (reset) begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
         end else if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
         end else if (bus.mem_req) begin
            if (wcnt >= ack_delay) begin
               bus.mem_ack = 1'b1;
               bus.mem_rdata = mem[bus.mem_addr];
               addr_log.push_back(bus.mem_addr);
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end
      end
   end

   always @(negedge clock) if (imm_valid) imm_pulses++;

   task automatic pulse_fetch();
      @(negedge clock); fetch_start = 1'b1;
      @(negedge clock); fetch_start = 1'b0;
   endtask

   task automatic pulse_imm();
      @(negedge clock); imm_fetch = 1'b1;
      @(negedge clock); imm_fetch = 1'b0;
   endtask

   task automatic load_pc(input logic [15:0] a, input bit with_fetch);
      @(negedge clock); pc_load = 1'b1; pc_load_value = a; fetch_start = with_fetch;
      @(negedge clock); pc_load = 1'b0; fetch_start = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (!busy) begin ok = 1'b1; break; end
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      bit ok;
      mem[16'h0000] = 8'h3E;
      ack_delay = 2;
      reset = 1'b1;
      @(negedge clock);
      total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h want 0000", pc); end
      total++; if ({bus.mem_req, inst_valid, imm_valid, busy, inst_is_cb} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {bus.mem_req, inst_valid, imm_valid, busy, inst_is_cb}); end
      total++; if ({bus.mem_addr, inst_buffer, imm_data} !== 40'h0) begin bad++; $display("FAIL reset_data: got %h want 0", {bus.mem_addr, inst_buffer, imm_data}); end
      reset = 1'b0;
      @(negedge clock);
      total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 16'h0000}) begin bad++; $display("FAIL boot_req: got %b/%h want 1/0000", bus.mem_req, bus.mem_addr); end
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL boot_timeout: got busy want idle"); end
      total++; if ({inst_buffer, inst_is_cb, inst_valid} !== {8'h3E, 1'b0, 1'b1}) begin bad++; $display("FAIL boot_inst: got %h/%b/%b want 3e/0/1", inst_buffer, inst_is_cb, inst_valid); end
      total++; if (pc !== 16'h0001) begin bad++; $display("FAIL boot_pc: got %h want 0001", pc); end
   endtask

   task automatic test_cb_prefix();
      bit ok;
      mem[16'h0100] = 8'hCB; mem[16'h0101] = 8'h7C;
      ack_delay = 1;
      load_pc(16'h0100, 1'b0);
      addr_log.delete();
      pulse_fetch();
      total++; if ({bus.mem_req, bus.mem_addr, inst_valid} !== {1'b1, 16'h0100, 1'b0}) begin bad++; $display("FAIL cb_first_req: got %b/%h/%b want 1/0100/0", bus.mem_req, bus.mem_addr, inst_valid); end
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL cb_timeout: got busy want idle"); end
      total++; if ({inst_buffer, inst_is_cb, inst_valid} !== {8'h7C, 1'b1, 1'b1}) begin bad++; $display("FAIL cb_inst: got %h/%b/%b want 7c/1/1", inst_buffer, inst_is_cb, inst_valid); end
      total++; if (pc !== 16'h0102) begin bad++; $display("FAIL cb_pc: got %h want 0102", pc); end
      total++; if (addr_log.size() != 2 || addr_log[0] !== 16'h0100 || addr_log[1] !== 16'h0101) begin bad++; $display("FAIL cb_reads: got %0d reads want 0100,0101", addr_log.size()); end
   endtask

   task automatic test_imm();
      bit ok;
      int p0;
      mem[16'h0102] = 8'h34; mem[16'h0103] = 8'h12;
      ack_delay = 0;
      p0 = imm_pulses;
      for (int k = 0; k < 2; k++) begin
         pulse_imm();
         wait_idle(ok);
         total++; if (!ok) begin bad++; $display("FAIL imm_timeout: got busy want idle"); end
      end
      @(negedge clock);
      total++; if (imm_data !== 16'h1234) begin bad++; $display("FAIL imm_data: got %h want 1234", imm_data); end
      total++; if (imm_pulses - p0 != 2) begin bad++; $display("FAIL imm_pulses: got %0d want 2", imm_pulses - p0); end
      total++; if ({inst_valid, inst_buffer, pc} !== {1'b1, 8'h7C, 16'h0104}) begin bad++; $display("FAIL imm_hold: got %b/%h/%h want 1/7c/0104", inst_valid, inst_buffer, pc); end
   endtask

   task automatic test_pc_load_mid();
      bit ok;
      mem[16'h0104] = 8'h55; mem[16'h8000] = 8'h77;
      ack_delay = 3;
      addr_log.delete();
      pulse_fetch();
      load_pc(16'h8000, 1'b0);
      total++; if ({busy, inst_valid} !== 2'b10) begin bad++; $display("FAIL redirect_busy: got %b want 10", {busy, inst_valid}); end
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL redirect_timeout: got busy want idle"); end
      total++; if ({inst_buffer, inst_is_cb, inst_valid} !== {8'h77, 1'b0, 1'b1}) begin bad++; $display("FAIL redirect_inst: got %h/%b/%b want 77/0/1", inst_buffer, inst_is_cb, inst_valid); end
      total++; if (pc !== 16'h8001) begin bad++; $display("FAIL redirect_pc: got %h want 8001", pc); end
      total++; if (addr_log.size() != 2 || addr_log[1] !== 16'h8000) begin bad++; $display("FAIL redirect_reads: got %0d reads want 2 ending 8000", addr_log.size()); end
   endtask

   task automatic test_wrap_and_reset();
      bit ok;
      mem[16'hFFFF] = 8'h00; mem[16'h2000] = 8'h42; mem[16'h0000] = 8'h3E;
      ack_delay = 0;
      load_pc(16'hFFFF, 1'b0);
      pulse_fetch();
      wait_idle(ok);
      total++; if ({ok, inst_buffer, pc} !== {1'b1, 8'h00, 16'h0000}) begin bad++; $display("FAIL wrap: got %b/%h/%h want 1/00/0000", ok, inst_buffer, pc); end
      load_pc(16'h2000, 1'b1);
      wait_idle(ok);
      total++; if ({ok, inst_buffer, pc} !== {1'b1, 8'h42, 16'h2001}) begin bad++; $display("FAIL load_fetch: got %b/%h/%h want 1/42/2001", ok, inst_buffer, pc); end
      ack_delay = 6;
      pulse_fetch();
      total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL pre_reset_req: got %b want 1", bus.mem_req); end
      #1 reset = 1'b1;
      #1;
      total++; if ({bus.mem_req, pc, inst_valid} !== {1'b0, 16'h0000, 1'b0}) begin bad++; $display("FAIL async_reset: got %b/%h/%b want 0/0000/0", bus.mem_req, pc, inst_valid); end
      @(negedge clock); reset = 1'b0; ack_delay = 1;
      @(negedge clock);
      wait_idle(ok);
      total++; if ({ok, inst_buffer, pc} !== {1'b1, 8'h3E, 16'h0001}) begin bad++; $display("FAIL reboot: got %b/%h/%h want 1/3e/0001", ok, inst_buffer, pc); end
   endtask

   // Program model: a fetch at P yields mem[P] (or mem[P+1] behind a CB prefix); immediates shift in high.
   task automatic test_random();
      bit ok;
      logic [15:0] mpc, a, mimm;
      logic [7:0]  mbuf;
      logic        mcb;
      int op;
      mpc = pc; mbuf = inst_buffer; mcb = inst_is_cb; mimm = imm_data;
      for (int it = 0; it < 30; it++) begin
         op = $urandom_range(0, 4);
         ack_delay = $urandom_range(0, 3);
         if (op == 4) begin
            pulse_imm();
            mimm = {mem[mpc], mimm[15:8]};
            mpc = mpc + 16'd1;
         end else begin
            if (op == 0) begin
               a = 16'($urandom);
               load_pc(a, 1'b1);
               mpc = a;
            end else begin
               pulse_fetch();
            end
            if (mem[mpc] == 8'hCB) begin
               mcb = 1'b1; mbuf = mem[mpc + 16'd1]; mpc = mpc + 16'd2;
            end else begin
               mcb = 1'b0; mbuf = mem[mpc]; mpc = mpc + 16'd1;
            end
         end
         wait_idle(ok);
         total++; if (!ok) begin bad++; $display("FAIL rnd_timeout it=%0d: got busy want idle", it); end
         total++; if (pc !== mpc) begin bad++; $display("FAIL rnd_pc it=%0d: got %h want %h", it, pc, mpc); end
         total++; if ({inst_buffer, inst_is_cb, inst_valid} !== {mbuf, mcb, 1'b1}) begin bad++; $display("FAIL rnd_inst it=%0d: got %h/%b/%b want %h/%b/1", it, inst_buffer, inst_is_cb, inst_valid, mbuf, mcb); end
         total++; if (imm_data !== mimm) begin bad++; $display("FAIL rnd_imm it=%0d: got %h want %h", it, imm_data, mimm); end
      end
   endtask

`ifdef INST_PREFETCH_EN
   task automatic test_prefetch();
      bit ok;
      ok = 1'b0;
      mem[16'h0001] = 8'h11; mem[16'h3000] = 8'h99;
      ack_delay = 0;
      repeat (6) @(negedge clock);
      pulse_fetch();
      total++; if ({inst_valid, inst_buffer, bus.mem_req} !== {1'b1, 8'h11, 1'b0}) begin bad++; $display("FAIL pf_hit: got %b/%h/%b want 1/11/0", inst_valid, inst_buffer, bus.mem_req); end
      load_pc(16'h3000, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (bus.mem_req && bus.mem_addr == 16'h3000) begin ok = 1'b1; break; end
         @(negedge clock);
      end
      total++; if (!ok) begin bad++; $display("FAIL pf_reload: got no read want read at 3000"); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 65536; i++)
         mem[i] = ($urandom_range(0, 5) == 0) ? 8'hCB : 8'($urandom);
      test_reset();
`ifdef INST_PREFETCH_EN
      test_prefetch();
`else
      test_cb_prefix();
      test_imm();
      test_pc_load_mid();
      test_wrap_and_reset();
      test_random();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end
endmodule
